// File: rtl/my_bus_transmitter_if.sv
// Command port and bus signals of the valid/a/b transmitter.
// The master modport is the transmitter; the slave modport is the command/bus partner.
interface my_bus_transmitter_if #(
  parameter int LEN_W = 4,
  parameter int GAP_W = 4,
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_a;
  logic             cmd_b;
  logic [LEN_W-1:0] cmd_len;
  logic [GAP_W-1:0] cmd_gap;
  logic             enable;
  logic             valid;
  logic             a;
  logic             b;
  logic             busy;
  logic [CNT_W-1:0] beat_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_len, cmd_gap, enable,
    output cmd_ready, valid, a, b, busy, beat_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_len, cmd_gap, enable,
    input  cmd_ready, valid, a, b, busy, beat_count
  );
endinterface

// File: rtl/my_bus_transmitter.sv
// Bus transmitter: command FIFO feeding an IDLE/SEND/GAP sequencer that drives
// bursts of registered valid/a/b beats separated by programmable idle gaps.
//
// state | meaning
// IDLE  | no command in flight; pops the FIFO head when enabled
// SEND  | issuing beats of the current command (stalls while enable is low)
// GAP   | forced idle cycles after the last beat of a command
module my_bus_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4,
  parameter int GAP_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  my_bus_transmitter_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = 2 + LEN_W + GAP_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_beats_left;
  logic [LEN_W-1:0] w_beats_left_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [GAP_W-1:0] w_gap_cnt_nxt;
  logic             r_cmd_a;
  logic             r_cmd_b;
  logic             w_cmd_a_nxt;
  logic             w_cmd_b_nxt;
  logic             w_valid_nxt;

  logic             r_valid;
  logic             r_a;
  logic             r_b;
  logic [CNT_W-1:0] r_beat_count;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {bus.cmd_a, bus.cmd_b, bus.cmd_len, bus.cmd_gap};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_beats_left <= '0;
      r_gap_cnt    <= '0;
      r_cmd_a      <= 1'b0;
      r_cmd_b      <= 1'b0;
      r_valid      <= 1'b0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_beat_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_cmd_a      <= w_cmd_a_nxt;
      r_cmd_b      <= w_cmd_b_nxt;
      r_valid      <= w_valid_nxt;
      r_a          <= w_valid_nxt & w_cmd_a_nxt;
      r_b          <= w_valid_nxt & w_cmd_b_nxt;
      if (r_valid) r_beat_count <= r_beat_count + CNT_W'(1);
    end
  end

  // The pop edge registers the first beat; r_beats_left counts beats still to issue.
  always_comb begin
    w_state_nxt      = r_state;
    w_beats_left_nxt = r_beats_left;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_cmd_a_nxt      = r_cmd_a;
    w_cmd_b_nxt      = r_cmd_b;
    w_valid_nxt      = 1'b0;
    w_pop            = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty && bus.enable) w_pop = 1'b1;
      end
      ST_SEND: begin
        if (r_beats_left != '0) begin
          if (bus.enable) begin
            w_valid_nxt      = 1'b1;
            w_beats_left_nxt = r_beats_left - LEN_W'(1);
          end
        end else if (r_gap_cnt != '0) begin
          w_state_nxt = ST_GAP;
        end else if (!w_empty && bus.enable) begin
          w_pop = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt == GAP_W'(1)) begin
          if (!w_empty && bus.enable) w_pop = 1'b1;
          else                        w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_pop) begin
      w_state_nxt      = ST_SEND;
      w_valid_nxt      = 1'b1;
      w_cmd_a_nxt      = w_head[ENT_W-1];
      w_cmd_b_nxt      = w_head[ENT_W-2];
      w_beats_left_nxt = w_head[GAP_W +: LEN_W];
      w_gap_cnt_nxt    = w_head[GAP_W-1:0];
    end
  end

  assign bus.cmd_ready  = !w_full;
  assign bus.valid      = r_valid;
  assign bus.a          = r_a;
  assign bus.b          = r_b;
  assign bus.busy       = (r_state != ST_IDLE) || !w_empty;
  assign bus.beat_count = r_beat_count;
endmodule

// File: tb/tb_my_bus_transmitter.sv
// Self-checking bench for my_bus_transmitter: directed scenarios plus randomized
// command/enable traffic compared against a beat-schedule reference model.
module tb_my_bus_transmitter;
  localparam int LEN_W = 4;
  localparam int GAP_W = 4;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;
  localparam int WIN   = 128;

  typedef struct packed {
    logic             a;
    logic             b;
    logic [LEN_W-1:0] len;
    logic [GAP_W-1:0] gap;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  my_bus_transmitter_if #(.LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();
  my_bus_transmitter_if #(.LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(4))     bus4 ();

  my_bus_transmitter #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  my_bus_transmitter #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .GAP_W(GAP_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4.master)
  );

  cmd_t       cmds[$];
  bit         en_pat[WIN];
  logic [3:0] trace[$];
  logic [2:0] exp_tr[WIN+1];
  bit         mon_on = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  always @(negedge clk) if (mon_on) trace.push_back({bus.busy, bus.valid, bus.a, bus.b});

  // Reference: each beat goes out on the first enabled edge at or after it becomes
  // eligible; a command's first beat is eligible last_beat_edge + 1 + gap.
  // Sample k+1 shows the beat registered on edge k.
  function automatic void build_exp();
    int t = 0;
    int earliest = 0;
    int last = 0;
    foreach (exp_tr[i]) exp_tr[i] = 3'b000;
    foreach (cmds[i]) begin
      if (t < earliest) t = earliest;
      for (int k = 0; k <= int'(cmds[i].len); k++) begin
        while (t < WIN && !en_pat[t]) t++;
        if (t < WIN) exp_tr[t+1] = {1'b1, cmds[i].a, cmds[i].b};
        last = t;
        t++;
      end
      earliest = last + 1 + int'(cmds[i].gap);
    end
  endfunction

  function automatic int total_beats();
    int s = 0;
    foreach (cmds[i]) s += int'(cmds[i].len) + 1;
    return s;
  endfunction

  function automatic int first_diff(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i >= trace.size()) return i;
      if (trace[i][2:0] !== exp_tr[i]) return i;
    end
    return -1;
  endfunction

  function automatic cmd_t rand_cmd(input int max_len, input int max_gap);
    cmd_t c;
    c.a   = 1'($urandom_range(1));
    c.b   = 1'($urandom_range(1));
    c.len = LEN_W'($urandom_range(max_len));
    c.gap = GAP_W'($urandom_range(max_gap));
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.enable = 1'b0;
    bus.cmd_a = 1'b0; bus.cmd_b = 1'b0; bus.cmd_len = '0; bus.cmd_gap = '0;
    bus4.cmd_valid = 1'b0; bus4.enable = 1'b0;
    bus4.cmd_a = 1'b0; bus4.cmd_b = 1'b0; bus4.cmd_len = '0; bus4.cmd_gap = '0;
    cmds.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push_cmd(input cmd_t c);
    int guard = 0;
    bus.cmd_a = c.a; bus.cmd_b = c.b; bus.cmd_len = c.len; bus.cmd_gap = c.gap;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: cmd_ready stayed %0b, wanted 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_window(input int n);
    bit acc;
    trace.delete();
    mon_on = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.enable = en_pat[k];
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (acc) bus.cmd_valid = 1'b0;
    end
    @(negedge clk); #1;
    mon_on = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", bus.valid); end
    n_cmp++; if (bus.a !== 1'b0) begin n_err++; $display("FAIL rst_a: got %0b want 0", bus.a); end
    n_cmp++; if (bus.b !== 1'b0) begin n_err++; $display("FAIL rst_b: got %0b want 0", bus.b); end
    n_cmp++; if (bus.beat_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.beat_count); end
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_basic_burst();
    int d = -1;
    logic [3:0] want;
    do_reset();
    bus.enable = 1'b1;
    trace.delete();
    mon_on = 1'b1;
    push_cmd('{a: 1'b1, b: 1'b0, len: LEN_W'(2), gap: GAP_W'(0)});
    repeat (6) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    mon_on = 1'b0;
    // Sample 1 follows the push edge; beats in samples 2..4; busy from push through last beat.
    for (int i = 0; i < 8; i++) begin
      want = {(i >= 1 && i <= 4), (i >= 2 && i <= 4), (i >= 2 && i <= 4), 1'b0};
      if (d < 0 && (i >= trace.size() || trace[i] !== want)) d = i;
    end
    n_cmp++;
    if (d >= 0) begin
      n_err++;
      $display("FAIL basic_trace: sample %0d got %b want busy/valid/a/b %b", d,
               (d < trace.size()) ? trace[d] : 4'bxxxx,
               {(d >= 1 && d <= 4), (d >= 2 && d <= 4), (d >= 2 && d <= 4), 1'b0});
    end
    n_cmp++; if (bus.beat_count !== 16'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", bus.beat_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %0b want 0", bus.busy); end
  endtask

  task automatic test_gap_b2b();
    int d;
    do_reset();
    cmds.push_back('{a: 1'b1, b: 1'b1, len: LEN_W'(1), gap: GAP_W'(3)});
    cmds.push_back('{a: 1'b0, b: 1'b1, len: LEN_W'(0), gap: GAP_W'(0)});
    foreach (cmds[i]) push_cmd(cmds[i]);
    foreach (en_pat[i]) en_pat[i] = 1'b1;
    build_exp();
    run_window(20);
    d = first_diff(20);
    n_cmp++;
    if (d >= 0) begin n_err++; $display("FAIL gap_trace: sample %0d got %b want %b", d, (d < trace.size()) ? trace[d][2:0] : 3'bxxx, exp_tr[d]); end
    n_cmp++; if (bus.beat_count !== 16'd3) begin n_err++; $display("FAIL gap_count: got %0d want 3", bus.beat_count); end
  endtask

  task automatic test_fifo_full();
    int d;
    cmd_t c;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      c = rand_cmd(5, 4);
      cmds.push_back(c);
      push_cmd(c);
      n_cmp++;
      if (bus.cmd_ready !== (i < DEPTH-1)) begin
        n_err++; $display("FAIL full_ready_%0d: got %0b want %0b", i, bus.cmd_ready, (i < DEPTH-1));
      end
    end
    c = rand_cmd(5, 4);
    cmds.push_back(c);
    bus.cmd_a = c.a; bus.cmd_b = c.b; bus.cmd_len = c.len; bus.cmd_gap = c.gap;
    bus.cmd_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_held: cmd_ready %0b want 0", bus.cmd_ready); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL full_disabled: valid %0b want 0", bus.valid); end
    foreach (en_pat[i]) en_pat[i] = 1'b1;
    build_exp();
    run_window(100);
    d = first_diff(100);
    n_cmp++;
    if (d >= 0) begin n_err++; $display("FAIL full_trace: sample %0d got %b want %b", d, (d < trace.size()) ? trace[d][2:0] : 3'bxxx, exp_tr[d]); end
    n_cmp++;
    if (bus.beat_count !== 16'(total_beats())) begin n_err++; $display("FAIL full_count: got %0d want %0d", bus.beat_count, total_beats()); end
  endtask

  task automatic test_stall();
    int d;
    do_reset();
    cmds.push_back('{a: 1'b1, b: 1'b1, len: LEN_W'(3), gap: GAP_W'(0)});
    push_cmd(cmds[0]);
    foreach (en_pat[i]) en_pat[i] = 1'b1;
    en_pat[2] = 1'b0;
    en_pat[3] = 1'b0;
    build_exp();
    run_window(12);
    d = first_diff(12);
    n_cmp++;
    if (d >= 0) begin n_err++; $display("FAIL stall_trace: sample %0d got %b want %b", d, (d < trace.size()) ? trace[d][2:0] : 3'bxxx, exp_tr[d]); end
    n_cmp++; if (bus.beat_count !== 16'd4) begin n_err++; $display("FAIL stall_count: got %0d want 4", bus.beat_count); end
  endtask

  task automatic test_reset_midburst();
    int highs = 0;
    do_reset();
    push_cmd('{a: 1'b1, b: 1'b0, len: LEN_W'(5), gap: GAP_W'(0)});
    push_cmd('{a: 1'b0, b: 1'b1, len: LEN_W'(1), gap: GAP_W'(0)});
    push_cmd('{a: 1'b1, b: 1'b1, len: LEN_W'(2), gap: GAP_W'(0)});
    bus.enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL mid_beat2: valid %0b want 1", bus.valid); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %0b want 0", bus.valid); end
    n_cmp++; if (bus.beat_count !== 16'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", bus.beat_count); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_flags: busy %0b ready %0b want 0 1", bus.busy, bus.cmd_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.valid) highs++;
    end
    n_cmp++; if (highs != 0) begin n_err++; $display("FAIL mid_after: %0d beats after release want 0", highs); end
    n_cmp++; if (bus.beat_count !== 16'd0) begin n_err++; $display("FAIL mid_after_count: got %0d want 0", bus.beat_count); end
  endtask

  task automatic test_random();
    int d;
    int ncmd;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      ncmd = $urandom_range(DEPTH, 1);
      for (int i = 0; i < ncmd; i++) cmds.push_back(rand_cmd(7, 5));
      foreach (cmds[i]) push_cmd(cmds[i]);
      foreach (en_pat[i]) en_pat[i] = ($urandom_range(3) != 0);
      build_exp();
      run_window(120);
      d = first_diff(120);
      n_cmp++;
      if (d >= 0) begin n_err++; $display("FAIL rand%0d_trace: sample %0d got %b want %b", r, d, (d < trace.size()) ? trace[d][2:0] : 3'bxxx, exp_tr[d]); end
      n_cmp++;
      if (bus.beat_count !== 16'(total_beats())) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, bus.beat_count, total_beats()); end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    bus4.enable = 1'b1;
    bus4.cmd_a = 1'b1; bus4.cmd_b = 1'b0; bus4.cmd_len = LEN_W'(15); bus4.cmd_gap = '0;
    bus4.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus4.cmd_len = LEN_W'(0);
    @(posedge clk); #1;
    bus4.cmd_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    n_cmp++; if (bus4.beat_count !== 4'd1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", bus4.beat_count); end
    n_cmp++; if (bus4.busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy: got %0b want 0", bus4.busy); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.enable = 1'b0;
    bus.cmd_a = 1'b0; bus.cmd_b = 1'b0; bus.cmd_len = '0; bus.cmd_gap = '0;
    bus4.cmd_valid = 1'b0; bus4.enable = 1'b0;
    bus4.cmd_a = 1'b0; bus4.cmd_b = 1'b0; bus4.cmd_len = '0; bus4.cmd_gap = '0;
    test_reset();
    test_basic_burst();
    test_gap_b2b();
    test_fifo_full();
    test_stall();
    test_reset_midburst();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/my_bus_transmitter.md
# my_bus_transmitter

Transmitting end of the `valid`/`a`/`b` single-bit bus. Accepts commands on a ready/valid port, buffers them in a small FIFO, and drives each command as a burst of `valid` beats carrying fixed `a`/`b` values, followed by a programmable idle gap. It sits on the driving side of the bus, opposite the monitor/receiver in the testbench, and produces all bus traffic from registered outputs.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `LEN_W`, 4: width of `cmd_len`.
- `GAP_W`, 4: width of `cmd_gap`.
- `CNT_W`, 16: width of `beat_count`.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: reset; **one clock, reset asynchronous and active-high**.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_a` in 1: value driven on `a` for every beat of the command.
- `cmd_b` in 1: value driven on `b` for every beat of the command.
- `cmd_len` in LEN_W: beats minus one (burst = `cmd_len`+1 beats).
- `cmd_gap` in GAP_W: idle cycles forced after the last beat.
- `enable` in 1: beat enable; low stalls beat issue.
- `valid` out 1: bus valid.
- `a` out 1: bus data a.
- `b` out 1: bus data b.
- `busy` out 1: FSM not IDLE or FIFO not empty.
- `beat_count` out CNT_W: total beats driven, wraps modulo 2^CNT_W.

## Operation
- Command push on `cmd_valid && cmd_ready`; `cmd_ready = !full` (no same-cycle pop bypass; full FIFO refuses push even if a pop occurs that cycle).
- FSM states: IDLE, SEND, GAP.
  - IDLE: if FIFO non-empty and `enable`, pop head, load beat counter = `cmd_len`, gap counter = `cmd_gap`, latch `a`/`b`, go SEND with `valid`=1 registered on the same edge.
  - SEND: each cycle with `enable`=1 emits one beat (`valid`=1). With `enable`=0: `valid`=0, beat counter frozen, stays SEND. On the edge issuing the last beat: if `cmd_gap`≠0 go GAP; else if FIFO non-empty and `enable`, pop next and stay SEND (back-to-back, `valid` continuous); else IDLE.
  - GAP: `valid`=0; gap counter decrements every cycle regardless of `enable`. On the edge where the counter reaches 1→0: pop and go SEND if FIFO non-empty and `enable`, else IDLE.
- `a`/`b` forced 0 whenever `valid`=0.
- `beat_count` increments on every edge registering a beat cycle (`valid`=1 cycle completed).
- `busy` combinational from state and FIFO empty.

## Timing
- Reset values: `valid`=0, `a`=0, `b`=0, `beat_count`=0, `cmd_ready`=1, `busy`=0; FSM IDLE; FIFO empty.
- Reset mid-burst: outputs clear asynchronously, FIFO contents and in-flight beats discarded; no beats issued until first edge after `reset` deasserts.
- Latency: command pushed at edge N into empty FIFO with FSM IDLE, `enable`=1 → `valid` high in cycle after edge N+1.
- Burst of L+1 beats with no stalls occupies exactly L+1 consecutive cycles; gap G gives exactly G cycles of `valid`=0 before the next burst, when next command is already queued.
- `cmd_len`=0: single beat. `cmd_gap`=0: back-to-back with next queued command.
- FIFO pointers wrap modulo `FIFO_DEPTH`; full/empty via extra pointer bit.
- `beat_count` wraps from 2^CNT_W−1 to 0 without flag.

## Test plan
- Reset, push {a=1,b=0,len=2,gap=0}: `valid` high 3 consecutive cycles starting cycle after edge N+1, a=1,b=0; `beat_count`=3; `busy` falls after last beat.
- Push two commands {len=1,gap=3,a=1,b=1} then {len=0,gap=0,a=0,b=1}: 2 beats, exactly 3 idle cycles, 1 beat; `beat_count`=3.
- Push 5 commands while `enable`=0: `cmd_ready` low after 4th push (DEPTH=4), 5th held; raise `enable` → all 5 bursts emitted in order.
- Mid-burst `enable` low 2 cycles on len=3 command: `valid` low 2 cycles, total still 4 beats, a/b=0 during stall.
- Assert `reset` during beat 2 of len=5 burst with 2 queued: `valid` drops immediately, `beat_count`=0, no further beats after release without new pushes.
- Preload `CNT_W`=4, drive 17 beats: `beat_count` reads 1.
